seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Decoder/receiver side of the team's active-low hex seven-segment encoding.
- Samples a multiplexed seven-segment display bus (segment lines plus per-digit anode enables) and rebuilds the hex nibble shown on each digit.
- Accepts a digit only after its pattern has been stable for a programmable number of cycles.
- Used as a board-level loopback checker and as a scoreboard tap for the display path in simulation.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines); legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_n  input  7  segment lines, active-low; bit0=a, bit1=b … bit6=g.
- an_n  input  NUM_DIGITS  digit enables, active-low; bit k selects digit k.
- err_clr  input  1  synchronous clear of all err_flags bits.
- digits  output  4*NUM_DIGITS  captured nibbles; digit k occupies bits [4k+3:4k].
- digit_valid  output  NUM_DIGITS  bit k set once digit k has had at least one valid capture.
- err_flags  output  NUM_DIGITS  sticky; bit k set when a stable but non-hex pattern is seen on digit k.
- upd  output  1  one-cycle pulse on each successful capture.
- upd_idx  output  3  index of the digit written on the cycle upd is high; otherwise holds its last value.

Behaviour:
- Reset (async, rst=1): digits=0, digit_valid=0, err_flags=0, upd=0, upd_idx=0, stability counter=0, sample registers=0. Reset asserted mid-run aborts any pending capture. The first capture after release needs a full STABLE_CYCLES run.
- Decode table, seg_n → nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0011000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
  - Every other pattern is invalid.
- Select qualification: sel_ok = exactly one bit of an_n low. Selected index k = position of that bit.
- Each edge, the block registers (k, seg_n) as the previous sample.
- Counter cnt (saturating at STABLE_CYCLES):
  - sel_ok=0 (blank, or more than one digit selected) → cnt←0, no capture.
  - sel_ok=1 and (k, seg_n) equals the previous sample and the previous cycle had sel_ok=1 → cnt←min(cnt+1, STABLE_CYCLES).
  - sel_ok=1 otherwise → cnt←1.
- Capture event: cnt==STABLE_CYCLES-1 and the increment condition holds, i.e. cnt transitions to STABLE_CYCLES. This fires exactly once per stable run; saturation prevents re-firing.
- On a capture with a valid pattern: digits[k]←decoded nibble, digit_valid[k]←1, upd←1, upd_idx←k. All are visible in the cycle after the capturing edge.
- On a capture with an invalid pattern: err_flags[k]←1. digits[k], digit_valid[k] and upd_idx are unchanged; upd stays 0.
- Latency: a pattern driven just before edge t0 and held produces its update after edge t0+STABLE_CYCLES-1. With the default, upd is high in the 4th cycle of the hold.
- upd is low on every cycle that is not a valid capture.
- err_clr=1 clears all err_flags on the next edge. If err_clr coincides with a new error on digit k, bit k is set and all other bits are cleared (set wins).
- A change of digit index with the same seg_n restarts the count (cnt←1).
- Recapturing the same value re-pulses upd; the block does not filter duplicates.
- Indices k ≥ NUM_DIGITS cannot occur. Unused upd_idx bits are 0.

Test Plan:
- Reset: rst=1 mid-count (cnt=2), release → all outputs 0. Hold an_n=1110, seg_n=0110000 for 4 cycles → upd pulses once in cycle 4, upd_idx=0, digits[3:0]=3, digit_valid=0001.
- Short glitch: an_n=1101, seg_n=0010010 for 3 cycles, then 0000010 for 4 cycles → only capture is 6 on digit 1; no upd during the first 3 cycles.
- Scan all: rotate an_n across 4 digits, 5 cycles each, showing A, b, C, d on digits 0..3 → digits=0xDCBA, digit_valid=1111, upd pulses with upd_idx 0,1,2,3 in order.
- Invalid pattern: digit 2, seg_n=1111111 held 6 cycles → err_flags=0100, upd never high, digits unchanged. Then err_clr for one cycle → err_flags=0000.
- Blank/multi-select: an_n=1111 or 1100 interleaved every 3rd cycle with a valid pattern → cnt never reaches 4, no capture, no error.
- Simultaneous: err_clr=1 on the same edge as an invalid capture on digit 3, with err_flags=0001 beforehand → err_flags=1000.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Seven-segment bus receiver: rebuilds hex nibbles from a multiplexed,
// active-low display bus once each digit's pattern has settled.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   err_flags,
    output logic                    upd,
    output logic [2:0]              upd_idx
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] sel;
    logic                  sel_ok;
    logic [2:0]            sel_k;

    logic [2:0]            prev_k;
    logic [6:0]            prev_seg;
    logic                  prev_ok;

    logic [7:0]            cnt;
    logic [7:0]            cnt_nxt;
    logic                  same;
    logic                  cap;

    logic                  dec_ok;
    logic [3:0]            dec_nib;
    logic                  cap_hit;
    logic                  cap_bad;

    // Maps an active-low segment pattern to its hex value; flags unknown shapes.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0011000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // Qualify the anode bus: exactly one digit enabled, and find which one.
    always_comb begin
        sel    = ~an_n;
        sel_ok = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        sel_k  = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                sel_k = 3'(i);
            end
        end
    end

    // Decode the live pattern; only consulted on a capture.
    always_comb begin
        {dec_ok, dec_nib} = seg_decode(seg_n);
    end

    // Stability tracking: same digit, same pattern, and both samples qualified.
    always_comb begin
        same    = sel_ok && prev_ok && (sel_k == prev_k) && (seg_n == prev_seg);
        cap     = same && (cnt == CNT_HIT);
        cap_hit = cap && dec_ok;
        cap_bad = cap && !dec_ok;
        if (!sel_ok) begin
            cnt_nxt = 8'd0;
        end else if (same) begin
            cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + 8'd1;
        end else begin
            cnt_nxt = 8'd1;
        end
    end

    // Previous-sample registers and the saturating run counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_k   <= 3'd0;
            prev_seg <= 7'd0;
            prev_ok  <= 1'b0;
            cnt      <= 8'd0;
        end else begin
            prev_k   <= sel_k;
            prev_seg <= seg_n;
            prev_ok  <= sel_ok;
            cnt      <= cnt_nxt;
        end
    end

    // Write the captured nibble into the selected digit slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_hit && sel[i]) begin
                    digits[4*i +: 4] <= dec_nib;
                    digit_valid[i]   <= 1'b1;
                end
            end
        end
    end

    // Update strobe and index; the index holds between captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd     <= 1'b0;
            upd_idx <= 3'd0;
        end else begin
            upd <= cap_hit;
            if (cap_hit) begin
                upd_idx <= sel_k;
            end
        end
    end

    // Sticky error flags; a new error on the clearing edge still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags <= '0;
        end else begin
            err_flags <= (err_clr ? '0 : err_flags) | (cap_bad ? sel : '0);
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus random bus traffic,
// all checked against a run-length reference model.
module tb_seven_seg_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_n = 7'h7f;
    logic [ND-1:0] an_n = '1;
    logic          err_clr = 1'b0;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic [ND-1:0] err_flags;
    logic          upd;
    logic [2:0]    upd_idx;

    int total = 0;
    int bad   = 0;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // reference model state
    int            run;
    logic [ND-1:0] last_an;
    logic [6:0]    last_seg;
    bit            last_ok;
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0] m_val;
    logic [ND-1:0] m_err;
    logic          m_upd;
    logic [2:0]    m_idx;
    int            upd_seen;

    seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .err_clr(err_clr), .digits(digits), .digit_valid(digit_valid),
        .err_flags(err_flags), .upd(upd), .upd_idx(upd_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; last_an = '1; last_seg = '0; last_ok = 0;
        m_dig = '0; m_val = '0; m_err = '0; m_upd = 0; m_idx = 0;
    endtask

    task automatic model_edge(input logic [ND-1:0] a, input logic [6:0] s,
                              input logic c);
        bit ok;
        bit valid;
        int k;
        int nib;
        ok = ($countones(~a) == 1);
        k = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) k = i;
        if (!ok) run = 0;
        else if (last_ok && a == last_an && s == last_seg) run++;
        else run = 1;
        valid = 0; nib = 0;
        for (int i = 0; i < 16; i++) if (tbl[i] == s) begin valid = 1; nib = i; end
        m_upd = 0;
        if (c) m_err = '0;
        if (ok && run == SC) begin
            if (valid) begin
                m_dig[4*k +: 4] = 4'(nib);
                m_val[k] = 1'b1;
                m_upd = 1;
                m_idx = 3'(k);
            end else begin
                m_err[k] = 1'b1;
            end
        end
        last_ok = ok; last_an = a; last_seg = s;
    endtask

    task automatic chk_all(input string ph);
        chk({ph, ".digits"}, 32'(digits), 32'(m_dig));
        chk({ph, ".valid"}, 32'(digit_valid), 32'(m_val));
        chk({ph, ".err"}, 32'(err_flags), 32'(m_err));
        chk({ph, ".upd"}, 32'(upd), 32'(m_upd));
        chk({ph, ".idx"}, 32'(upd_idx), 32'(m_idx));
    endtask

    task automatic step(input string ph, input logic [ND-1:0] a,
                        input logic [6:0] s, input logic c);
        an_n = a; seg_n = s; err_clr = c;
        @(posedge clk);
        #1;
        model_edge(a, s, c);
        if (upd === 1'b1) upd_seen++;
        chk_all(ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk_all("por");
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a count, then a clean run of 4
        step("pre", 4'b1110, 7'b0110000, 0);
        step("pre", 4'b1110, 7'b0110000, 0);
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step("hold3", 4'b1110, 7'b0110000, 0);
            chk("hold3.updcyc", 32'(upd), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("hold3.nib", 32'(digits[3:0]), 32'd3);
        chk("hold3.dv", 32'(digit_valid), 32'b0001);
        chk("hold3.i", 32'(upd_idx), 32'd0);

        // short glitch, then a settled 6 on digit 1
        upd_seen = 0;
        for (int i = 0; i < 3; i++) step("glitch", 4'b1101, 7'b0010010, 0);
        chk("glitch.none", 32'(upd_seen), 32'd0);
        for (int i = 0; i < 4; i++) step("glitch6", 4'b1101, 7'b0000010, 0);
        chk("glitch.one", 32'(upd_seen), 32'd1);
        chk("glitch.nib", 32'(digits[7:4]), 32'd6);

        // scan A b C d across digits 0..3
        for (int d = 0; d < 4; d++) begin
            for (int i = 1; i <= 5; i++) begin
                step("scan", ~(4'b0001 << d), tbl[10+d], 0);
                if (i == 4) chk("scan.idx", 32'(upd_idx), 32'(d));
            end
        end
        chk("scan.dig", 32'(digits), 32'hDCBA);
        chk("scan.dv", 32'(digit_valid), 32'hF);

        // invalid pattern on digit 2, then clear
        upd_seen = 0;
        for (int i = 0; i < 6; i++) step("inval", 4'b1011, 7'b1111111, 0);
        chk("inval.err", 32'(err_flags), 32'b0100);
        chk("inval.noupd", 32'(upd_seen), 32'd0);
        chk("inval.dig", 32'(digits), 32'hDCBA);
        step("clr", 4'b1111, 7'b1111111, 1);
        chk("clr.err", 32'(err_flags), 32'd0);

        // error on digit 0, then clear coinciding with error on digit 3
        for (int i = 0; i < 4; i++) step("e0", 4'b1110, 7'b1111111, 0);
        chk("e0.err", 32'(err_flags), 32'b0001);
        for (int i = 0; i < 3; i++) step("e3", 4'b0111, 7'b1111111, 0);
        step("e3clr", 4'b0111, 7'b1111111, 1);
        chk("simul.err", 32'(err_flags), 32'b1000);

        // blank / multi-select every third cycle keeps the run short
        upd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 2) step("blank", (i % 2) ? 4'b1100 : 4'b1111, tbl[8], 0);
            else step("blank", 4'b1110, tbl[8], 0);
        end
        chk("blank.noupd", 32'(upd_seen), 32'd0);
        chk("blank.err", 32'(err_flags), 32'b1000);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            logic [ND-1:0] a;
            logic [6:0] s;
            int mode;
            int len;
            int p;
            int q;
            mode = $urandom_range(0, 9);
            if (mode == 0) a = '1;
            else if (mode == 1) begin
                p = $urandom_range(0, ND-1);
                q = (p + $urandom_range(1, ND-1)) % ND;
                a = ~((4'b0001 << p) | (4'b0001 << q));
            end else a = ~(4'b0001 << $urandom_range(0, ND-1));
            if ($urandom_range(0, 4) == 0) s = 7'($urandom);
            else s = tbl[$urandom_range(0, 15)];
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++)
                step("rand", a, s, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
